// File: rtl/mult_div_unit_if.sv
// Pipeline <-> multiply/divide unit connection: E-stage request fields going
// in, busy / HI / LO / mf read data coming back.
interface mult_div_unit_if;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  // Pipeline side: issues operations and reads results.
  modport master (
    output start, mdu_op, rs_val, rt_val,
    input  busy, hi, lo, rd_data
  );

  // Unit side.
  modport slave (
    input  start, mdu_op, rs_val, rt_val,
    output busy, hi, lo, rd_data
  );
endinterface

// File: rtl/mult_div_unit.sv
// MIPS E-stage multiply/divide unit. Owns HI/LO, runs mult/div for a fixed
// number of cycles with busy held high, and serves mthi/mtlo/mfhi/mflo.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] count;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [3:0]       op_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic             is_md_op;
  logic             accept;

  // Start is honoured only from IDLE and only for the four arithmetic ops;
  // anything else (including a start while busy) is dropped.
  assign is_md_op = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU) ||
                    (bus.mdu_op == OP_DIV)  || (bus.mdu_op == OP_DIVU);
  assign accept   = (state == S_IDLE) && bus.start && is_md_op;

  // Products from the captured operands; operands are widened first so the
  // full 64-bit result is produced.
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  assign prod_s = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
  assign prod_u = {32'd0, op_a} * {32'd0, op_b};

  // Signed division is done on magnitudes and the signs are reapplied, which
  // also makes 0x80000000 / -1 fall out as 0x80000000 rem 0 without overflow.
  logic        a_neg;
  logic        b_neg;
  logic        div_signed;
  logic        div_zero;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quot_u;
  logic [31:0] rem_u;

  assign a_neg      = op_a[31];
  assign b_neg      = op_b[31];
  assign div_signed = (op_q == OP_DIV);
  assign div_zero   = (op_b == 32'd0);
  assign dividend   = (div_signed && a_neg) ? (32'd0 - op_a) : op_a;
  // Substitute 1 for a zero divisor so the divider never sees x/0; the
  // result is discarded in that case anyway.
  assign divisor    = div_zero ? 32'd1 : ((div_signed && b_neg) ? (32'd0 - op_b) : op_b);
  assign quot_u     = dividend / divisor;
  assign rem_u      = dividend % divisor;

  logic        res_we;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Select the HI/LO values written on the completion edge.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a value unassigned and infers a latch.
    res_we = 1'b0;
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OP_MULT: begin
        res_we = 1'b1;
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_we = 1'b1;
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        res_we = !div_zero;
        res_lo = (a_neg ^ b_neg) ? (32'd0 - quot_u) : quot_u;
        res_hi = a_neg ? (32'd0 - rem_u) : rem_u;
      end
      OP_DIVU: begin
        res_we = !div_zero;
        res_lo = quot_u;
        res_hi = rem_u;
      end
      default: ;
    endcase
  end

  // Control FSM, operand capture and HI/LO update.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: all state here is a register updated with non-blocking assignments
    // so every read in this block sees the pre-edge value.
    if (!reset) begin
      state <= S_IDLE;
      count <= '0;
      op_a  <= '0;
      op_b  <= '0;
      op_q  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_a  <= bus.rs_val;
            op_b  <= bus.rt_val;
            op_q  <= bus.mdu_op;
            count <= ((bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
            state <= S_RUN;
          end else if (bus.mdu_op == OP_MTHI) begin
            hi_q <= bus.rs_val;
          end else if (bus.mdu_op == OP_MTLO) begin
            lo_q <= bus.rs_val;
          end
        end
        S_RUN: begin
          count <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            state <= S_IDLE;
            if (res_we) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == S_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // mf read path straight from the HI/LO registers.
  always_comb begin
    case (bus.mdu_op)
      OP_MFHI: bus.rd_data = hi_q;
      OP_MFLO: bus.rd_data = lo_q;
      default: bus.rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus a random
// run, checked against a plain-arithmetic HI/LO reference model.
module tb_mult_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit_if bus ();

  mult_div_unit #(
    .MULT_CYCLES(MULT_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what HI/LO must hold after an op completes.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          p;
    longint unsigned pu;
    longint          la;
    longint          lb;
    longint          q;
    longint          r;
    case (op)
      4'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      4'd2: begin
        pu = longint'({32'd0, a}) * longint'({32'd0, b});
        m_hi = pu[63:32];
        m_lo = pu[31:0];
      end
      4'd3: if (b != 0) begin
        la = longint'($signed(a));
        lb = longint'($signed(b));
        q = la / lb;
        r = la % lb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      4'd4: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue a mult/div, check busy for exactly the expected cycle count, then results.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = (op <= 4'd2) ? MULT_N : DIV_N;
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.rs_val = a;
    bus.rt_val = b;
    step();
    bus.start  = 1'b0;
    bus.mdu_op = 4'd0;
    for (int i = 1; i <= n; i++) begin
      check({tag, "_busy_hi"}, {31'd0, bus.busy}, 32'd1);
      step();
    end
    check({tag, "_busy_lo"}, {31'd0, bus.busy}, 32'd0);
    model_op(op, a, b);
    check({tag, "_hi"}, bus.hi, m_hi);
    check({tag, "_lo"}, bus.lo, m_lo);
  endtask

  task automatic move_to(input string tag, input logic [3:0] op, input logic [31:0] v);
    bus.mdu_op = op;
    bus.rs_val = v;
    step();
    bus.mdu_op = 4'd0;
    model_op(op, v, 32'd0);
    check({tag, "_hi"}, bus.hi, m_hi);
    check({tag, "_lo"}, bus.lo, m_lo);
  endtask

  task automatic read_check(input string tag);
    bus.mdu_op = 4'd7;
    #1;
    check({tag, "_mfhi"}, bus.rd_data, m_hi);
    bus.mdu_op = 4'd8;
    #1;
    check({tag, "_mflo"}, bus.rd_data, m_lo);
    bus.mdu_op = 4'd0;
    #1;
    check({tag, "_rd_none"}, bus.rd_data, 32'd0);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] cap_a;
    logic [31:0] cap_b;

    checks     = 0;
    errors     = 0;
    m_hi       = 32'd0;
    m_lo       = 32'd0;
    bus.start  = 1'b0;
    bus.mdu_op = 4'd0;
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;

    // T1: reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    check("t1_busy", {31'd0, bus.busy}, 32'd0);
    check("t1_hi", bus.hi, 32'd0);
    check("t1_lo", bus.lo, 32'd0);
    read_check("t1");

    // T2: mult / multu of -2 and 3
    run_op("t2_mult", 4'd1, 32'hFFFF_FFFE, 32'd3);
    check("t2_mult_hi_const", bus.hi, 32'hFFFF_FFFF);
    check("t2_mult_lo_const", bus.lo, 32'hFFFF_FFFA);
    run_op("t2_multu", 4'd2, 32'hFFFF_FFFE, 32'd3);
    check("t2_multu_hi_const", bus.hi, 32'h0000_0002);
    check("t2_multu_lo_const", bus.lo, 32'hFFFF_FFFA);
    read_check("t2");

    // T3: signed and unsigned divide, plus the overflow corner
    run_op("t3_div", 4'd3, 32'hFFFF_FFF9, 32'd2);
    check("t3_div_lo_const", bus.lo, 32'hFFFF_FFFD);
    check("t3_div_hi_const", bus.hi, 32'hFFFF_FFFF);
    run_op("t3_divu", 4'd4, 32'd7, 32'd2);
    check("t3_divu_lo_const", bus.lo, 32'd3);
    check("t3_divu_hi_const", bus.hi, 32'd1);
    run_op("t3_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("t3_ovf_lo_const", bus.lo, 32'h8000_0000);
    check("t3_ovf_hi_const", bus.hi, 32'd0);

    // T4: mthi then divide by zero leaves HI/LO alone
    move_to("t4_mthi", 4'd5, 32'h0000_1234);
    move_to("t4_mtlo", 4'd6, 32'hCAFE_0001);
    run_op("t4_div0", 4'd3, 32'd99, 32'd0);
    check("t4_div0_hi_const", bus.hi, 32'h0000_1234);
    check("t4_div0_lo_const", bus.lo, 32'hCAFE_0001);
    run_op("t4_divu0", 4'd4, 32'hFFFF_0000, 32'd0);

    // T5: operand changes, extra start and mtlo while busy are ignored
    cap_a = 32'h0001_2345;
    cap_b = 32'hFFFF_FF00;
    bus.start  = 1'b1;
    bus.mdu_op = 4'd1;
    bus.rs_val = cap_a;
    bus.rt_val = cap_b;
    step();
    bus.start  = 1'b0;
    bus.mdu_op = 4'd0;
    for (int i = 1; i <= MULT_N; i++) begin
      check("t5_busy_hi", {31'd0, bus.busy}, 32'd1);
      bus.rs_val = $urandom;
      bus.rt_val = $urandom;
      if (i == 2) begin
        bus.start  = 1'b1;
        bus.mdu_op = 4'd4;
      end else if (i == 3) begin
        bus.start  = 1'b0;
        bus.mdu_op = 4'd6;
        bus.rs_val = 32'hDEAD_BEEF;
      end else begin
        bus.start  = 1'b0;
        bus.mdu_op = 4'd0;
      end
      step();
    end
    bus.mdu_op = 4'd0;
    check("t5_busy_lo", {31'd0, bus.busy}, 32'd0);
    model_op(4'd1, cap_a, cap_b);
    check("t5_hi", bus.hi, m_hi);
    check("t5_lo", bus.lo, m_lo);
    // Back-to-back: start issued on the very first idle cycle
    run_op("t5_b2b", 4'd4, 32'd1000, 32'd7);
    run_op("t5_b2b2", 4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);

    // Randomized mix of ops with model checking
    for (int k = 0; k < 24; k++) begin
      op = 4'($urandom_range(1, 6));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
      if (op >= 4'd5) move_to("rnd_mt", op, a);
      else            run_op("rnd_op", op, a, b);
      read_check("rnd");
    end

    // T6: reset mid-mult drops busy at once and clears HI/LO
    check("t6_pre_nonzero", {31'd0, (bus.hi != 32'd0) || (bus.lo != 32'd0)}, 32'd1);
    bus.start  = 1'b1;
    bus.mdu_op = 4'd2;
    bus.rs_val = 32'h1234_5678;
    bus.rt_val = 32'h9ABC_DEF0;
    step();
    bus.start  = 1'b0;
    bus.mdu_op = 4'd0;
    step();
    step();
    check("t6_busy_before", {31'd0, bus.busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("t6_busy_async", {31'd0, bus.busy}, 32'd0);
    check("t6_hi_async", bus.hi, m_hi);
    check("t6_lo_async", bus.lo, m_lo);
    #2;
    reset = 1'b1;
    repeat (MULT_N + 4) step();
    check("t6_busy_late", {31'd0, bus.busy}, 32'd0);
    check("t6_hi_late", bus.hi, m_hi);
    check("t6_lo_late", bus.lo, m_lo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
